// File: rtl/kbd_xt_host_ctrl.sv
// Host side of the XT keyboard link: generates KBD_CLK, deserialises frames into
// SCAN_CODE/IRQ1, inhibits the link while a code is held, and sequences KBD_RESET_N.
module kbd_xt_host_ctrl #(
   parameter int CLK_DIV    = 8,
   parameter int RST_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   output logic       KBD_CLK,
   input  logic       KBD_DATA,
   output logic       KBD_RESET_N,
   input  logic       CLK_EN,
   input  logic       CLEAR,
   input  logic       RESET_REQ,
   output logic [7:0] SCAN_CODE,
   output logic       IRQ1,
   output logic       FRAME_ERR
);

   typedef enum logic [1:0] {IDLE, START2, DATA, FULL} state_t;

   localparam logic [7:0]  DIV_TC  = 8'(CLK_DIV - 1);
   localparam logic [15:0] RST_LEN = 16'(RST_CYCLES);

   state_t      state;
   logic        sync1, sync2;
   logic [7:0]  div_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic [15:0] rst_cnt;
   logic [15:0] rst_cnt_next;
   logic        reset_active;
   logic        run;
   logic        strobe;

   assign reset_active = (rst_cnt != 16'd0);
   assign run          = CLK_EN & ~CLEAR & (state != FULL) & ~reset_active;
   // A strobe is only a divider-driven 1->0 transition, never a forced fall.
   assign strobe       = run & (div_cnt == DIV_TC) & KBD_CLK;

   always_comb begin
      rst_cnt_next = rst_cnt;
      if (RESET_REQ)
         rst_cnt_next = RST_LEN;
      else if (rst_cnt != 16'd0)
         rst_cnt_next = rst_cnt - 16'd1;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1       <= 1'b1;
         sync2       <= 1'b1;
         rst_cnt     <= 16'd0;
         KBD_RESET_N <= 1'b1;
      end else begin
         sync1       <= KBD_DATA;
         sync2       <= sync1;
         rst_cnt     <= rst_cnt_next;
         KBD_RESET_N <= (rst_cnt_next == 16'd0);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         div_cnt <= 8'd0;
         KBD_CLK <= 1'b0;
      end else if (!run) begin
         div_cnt <= 8'd0;
         KBD_CLK <= 1'b0;
      end else if (div_cnt == DIV_TC) begin
         div_cnt <= 8'd0;
         KBD_CLK <= ~KBD_CLK;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         SCAN_CODE <= 8'h00;
         IRQ1      <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else if (CLEAR) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         SCAN_CODE <= 8'h00;
         IRQ1      <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else if (RESET_REQ || reset_active) begin
         // Keyboard reset drops any partial frame but keeps the held code/flags.
         state   <= IDLE;
         bit_cnt <= 3'd0;
         shreg   <= 8'h00;
      end else if (strobe) begin
         case (state)
            IDLE: begin
               if (!sync2) state <= START2;
            end
            START2: begin
               bit_cnt <= 3'd0;
               if (!sync2) begin
                  state <= DATA;
               end else begin
                  FRAME_ERR <= 1'b1;
                  state     <= IDLE;
               end
            end
            DATA: begin
               shreg <= {sync2, shreg[7:1]};
               if (bit_cnt == 3'd7) begin
                  SCAN_CODE <= {sync2, shreg[7:1]};
                  IRQ1      <= 1'b1;
                  state     <= FULL;
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            default: state <= FULL;
         endcase
      end
   end

endmodule

// File: tb/tb_kbd_xt_host_ctrl.sv
// Scoreboard bench for kbd_xt_host_ctrl: a translator model shifts frames out on
// each KBD_CLK rise and a monitor checks every IRQ1 / FRAME_ERR event in order.
module tb_kbd_xt_host_ctrl;

   localparam int CLK_DIV    = 4;
   localparam int RST_CYCLES = 16;

   logic       clk;
   logic       rst_n;
   logic       kbd_clk;
   logic       kbd_data;
   logic       kbd_reset_n;
   logic       clk_en;
   logic       clear;
   logic       reset_req;
   logic [7:0] scan_code;
   logic       irq1;
   logic       frame_err;

   int checks   = 0;
   int failures = 0;

   bit         tx_q[$];
   logic [8:0] exp_q[$];   // {is_frame_err, scan_code}
   bit         ferr_model = 1'b0;

   kbd_xt_host_ctrl #(.CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES)) dut (
      .CLK(clk),
      .RESET_N(rst_n),
      .KBD_CLK(kbd_clk),
      .KBD_DATA(kbd_data),
      .KBD_RESET_N(kbd_reset_n),
      .CLK_EN(clk_en),
      .CLEAR(clear),
      .RESET_REQ(reset_req),
      .SCAN_CODE(scan_code),
      .IRQ1(irq1),
      .FRAME_ERR(frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Translator model: next frame bit appears on each KBD_CLK rise; keyboard reset flushes it.
   initial begin
      kbd_data = 1'b1;
      forever begin
         @(posedge kbd_clk or negedge kbd_reset_n or negedge rst_n);
         if (!kbd_reset_n || !rst_n) begin
            tx_q.delete();
            kbd_data = 1'b1;
         end else if (tx_q.size() != 0) begin
            kbd_data = tx_q.pop_front();
         end else begin
            kbd_data = 1'b1;
         end
      end
   end

   // Monitor: every rising IRQ1 or FRAME_ERR consumes one expected event.
   initial begin
      logic       p_irq, p_ferr, p_kclk;
      logic [8:0] e;
      p_irq = 0; p_ferr = 0; p_kclk = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_irq = 0; p_ferr = 0; p_kclk = 0;
         end else begin
            if (irq1 && !p_irq) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_irq", {23'd0, 1'b0, scan_code}, 32'h1ff);
               end else begin
                  e = exp_q.pop_front();
                  check("event_kind_irq", {31'd0, e[8]}, 32'd0);
                  check("scan_code", {24'd0, scan_code}, {24'd0, e[7:0]});
                  check("irq_at_strobe", {31'd0, p_kclk & ~kbd_clk}, 32'd1);
               end
            end
            if (frame_err && !p_ferr) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_ferr", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("event_kind_ferr", {31'd0, e[8]}, 32'd1);
               end
            end
            p_irq = irq1; p_ferr = frame_err; p_kclk = kbd_clk;
         end
      end
   end

   task automatic send_frame(input logic [7:0] code, input bit bad, input int pause_at,
                             input int pause_len, input int reset_at);
      bit prev;
      bit held;
      int falls, n, total, low, clk_low;
      if (bad) begin
         tx_q.push_back(1'b0);
         tx_q.push_back(1'b1);
      end else begin
         tx_q.push_back(1'b0);
         tx_q.push_back(1'b0);
         for (int i = 0; i < 8; i++) tx_q.push_back(code[i]);
      end
      total = tx_q.size();
      if (reset_at == 0) begin
         if (bad) begin
            if (!ferr_model) exp_q.push_back({1'b1, 8'h00});
            ferr_model = 1'b1;
         end else begin
            exp_q.push_back({1'b0, code});
         end
      end
      falls = 0; n = 0; prev = kbd_clk;
      while (tx_q.size() != 0 && n < 3000) begin
         @(posedge clk); #1; n++;
         if (prev && !kbd_clk && (total - int'(tx_q.size())) > falls) begin
            falls++;
            if (falls == pause_at) begin
               clk_en = 1'b0;
               @(posedge clk); #1;
               check("inhibit_clk", {31'd0, kbd_clk}, 32'd0);
               held = 1'b1;
               repeat (pause_len) begin
                  @(posedge clk); #1;
                  if (kbd_clk) held = 1'b0;
               end
               check("inhibit_hold", {31'd0, held}, 32'd1);
               clk_en = 1'b1;
            end
            if (falls == reset_at) begin
               reset_req = 1'b1;
               @(posedge clk); #1;
               reset_req = 1'b0;
               low = 0; clk_low = 1;
               for (int k = 0; k < 40; k++) begin
                  if (!kbd_reset_n) begin
                     low++;
                     if (kbd_clk) clk_low = 0;
                  end
                  @(posedge clk); #1;
               end
               check("reset_len", low, RST_CYCLES);
               check("reset_clk_low", clk_low, 1);
               check("reset_keeps_irq", {31'd0, irq1}, 32'd0);
            end
         end
         prev = kbd_clk;
      end
      check("tx_drain", tx_q.size(), 0);
      repeat (14) @(posedge clk);
      #1;
      if (reset_at == 0) begin
         if (bad) begin
            check("ferr_set", {31'd0, frame_err}, 32'd1);
            check("irq_after_bad", {31'd0, irq1}, 32'd0);
         end else begin
            check("irq_set", {31'd0, irq1}, 32'd1);
         end
      end
   endtask

   task automatic pulse_clear();
      int n;
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      ferr_model = 1'b0;
      check("clear_irq", {31'd0, irq1}, 32'd0);
      check("clear_code", {24'd0, scan_code}, 32'd0);
      check("clear_ferr", {31'd0, frame_err}, 32'd0);
      n = 0;
      while (n < 20) begin
         @(posedge clk); #1;
         n++;
         if (kbd_clk) break;
      end
      check("first_rise", n, CLK_DIV);
   endtask

   initial begin
      bit held;
      bit bad;
      int pause;
      rst_n = 1'b0; clk_en = 1'b0; clear = 1'b0; reset_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_kbd_clk", {31'd0, kbd_clk}, 32'd0);
      check("rst_kbd_reset_n", {31'd0, kbd_reset_n}, 32'd1);
      check("rst_scan_code", {24'd0, scan_code}, 32'd0);
      check("rst_irq", {31'd0, irq1}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      rst_n = 1'b1;
      clk_en = 1'b1;

      send_frame(8'h1E, 1'b0, 0, 0, 0);
      held = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (kbd_clk) held = 1'b0;
      end
      check("full_inhibit", {31'd0, held}, 32'd1);
      pulse_clear();

      send_frame(8'h9E, 1'b0, 0, 0, 0);
      pulse_clear();

      send_frame(8'h00, 1'b1, 0, 0, 0);
      send_frame(8'h2C, 1'b0, 0, 0, 0);
      check("ferr_sticky", {31'd0, frame_err}, 32'd1);
      pulse_clear();

      send_frame(8'h5A, 1'b0, 6, 50, 0);
      pulse_clear();

      send_frame(8'h33, 1'b0, 0, 0, 5);
      send_frame(8'h10, 1'b0, 0, 0, 0);
      pulse_clear();

      for (int r = 0; r < 14; r++) begin
         bad   = ($urandom_range(0, 4) == 0);
         pause = (!bad && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : 0;
         send_frame(8'($urandom_range(0, 255)), bad, pause, int'($urandom_range(5, 60)), 0);
         if (!bad) pulse_clear();
      end
      pulse_clear();

      // Asynchronous reset mid-frame with FRAME_ERR set.
      send_frame(8'h00, 1'b1, 0, 0, 0);
      for (int i = 0; i < 10; i++) tx_q.push_back(i < 2 ? 1'b0 : 1'b1);
      repeat (30) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_kbd_clk", {31'd0, kbd_clk}, 32'd0);
      check("arst_kbd_reset_n", {31'd0, kbd_reset_n}, 32'd1);
      check("arst_scan_code", {24'd0, scan_code}, 32'd0);
      check("arst_irq", {31'd0, irq1}, 32'd0);
      check("arst_ferr", {31'd0, frame_err}, 32'd0);
      ferr_model = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Asynchronous reset in the middle of a keyboard reset pulse.
      @(posedge clk); #1;
      reset_req = 1'b1;
      @(posedge clk); #1;
      reset_req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pulse_active", {31'd0, kbd_reset_n}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst2_kbd_reset_n", {31'd0, kbd_reset_n}, 32'd1);
      check("arst2_kbd_clk", {31'd0, kbd_clk}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      send_frame(8'hA5, 1'b0, 0, 0, 0);
      pulse_clear();

      repeat (10) @(posedge clk);
      check("exp_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
